user_digit_entry: RTL and testbench

//  Front end of the player-ID entry path. Synchronises the raw digit switches and load button.

---
 rtl/entry_pkg.sv | 25 ++
 rtl/user_digit_entry_if.sv | 24 ++
 rtl/debounce_sync.sv | 51 +++++
 rtl/user_digit_entry.sv | 75 +++++++
 tb/tb_user_digit_entry.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/entry_pkg.sv
// Shared constants and types for the player-ID digit entry path.
package entry_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned MAX_DIGIT     = 9;
  localparam int unsigned DIGITS_PER_ID = 4;
  localparam int unsigned COUNT_W       = 3;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [COUNT_W-1:0] count_t;

  // Registered output payload presented to PlayerID_Authentication.
  typedef struct packed {
    digit_t digit;
    logic   load;
    logic   error;
    logic   done;
    count_t count;
  } entry_out_t;

  function automatic logic digit_legal(input digit_t d);
    return d <= DIGIT_W'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/user_digit_entry_if.sv
// Switch-side inputs and authentication-side outputs of the digit entry block.
interface user_digit_entry_if;
  import entry_pkg::*;

  digit_t RawDigit;
  logic   RawLoad;
  logic   logout;
  digit_t UserDigit;
  logic   UserLoad;
  logic   DigitError;
  count_t DigitCount;
  logic   EntryDone;

  modport master (
    output RawDigit, RawLoad, logout,
    input  UserDigit, UserLoad, DigitError, DigitCount, EntryDone
  );

  modport slave (
    input  RawDigit, RawLoad, logout,
    output UserDigit, UserLoad, DigitError, DigitCount, EntryDone
  );

endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus stable-count debouncer for one bouncing input.
// Any sample equal to the current debounced level restarts the count.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o,
  output logic rise_c_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d, deb_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign deb_o    = deb_q;
  assign rise_c_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/user_digit_entry.sv
// Player-ID digit entry: synchronised digit switches, debounced load button,
// digit validation and per-attempt digit counting with one-cycle strobes.
module user_digit_entry
  import entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input logic               clk,
  input logic               rst,
  user_digit_entry_if.slave bus
);

  localparam count_t COUNT_LAST = COUNT_W'(DIGITS_PER_ID - 1);

  digit_t     dig_sync1_q, dig_sync2_q;
  logic       load_deb, load_rise_c, press_c;
  entry_out_t out_q, out_d;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load_db (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.RawLoad),
    .deb_o   (load_deb),
    .rise_c_o(load_rise_c)
  );

  assign press_c = load_rise_c & load_deb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_sync1_q <= '0;
      dig_sync2_q <= '0;
      out_q       <= '0;
    end else begin
      dig_sync1_q <= bus.RawDigit;
      dig_sync2_q <= dig_sync1_q;
      out_q       <= out_d;
    end
  end

  // Logout wins over a coincident press; an illegal digit leaves digit and count alone.
  always_comb begin
    out_d       = out_q;
    out_d.load  = 1'b0;
    out_d.error = 1'b0;
    out_d.done  = 1'b0;
    if (bus.logout) begin
      out_d.count = '0;
    end else if (press_c) begin
      if (!digit_legal(dig_sync2_q)) begin
        out_d.error = 1'b1;
      end else begin
        out_d.digit = dig_sync2_q;
        out_d.load  = 1'b1;
        if (out_q.count == COUNT_LAST) begin
          out_d.count = '0;
          out_d.done  = 1'b1;
        end else begin
          out_d.count = out_q.count + COUNT_W'(1);
        end
      end
    end
  end

  assign bus.UserDigit  = out_q.digit;
  assign bus.UserLoad   = out_q.load;
  assign bus.DigitError = out_q.error;
  assign bus.EntryDone  = out_q.done;
  assign bus.DigitCount = out_q.count;

endmodule

// File: tb/tb_user_digit_entry.sv
// Bench for user_digit_entry: directed scenarios plus random presses, checked
// every cycle against a sliding-window model of the debounced entry path.
module tb_user_digit_entry;

  localparam int unsigned D     = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned N_ID  = 4;
  localparam int unsigned MAXD  = 9;

  logic clk = 1'b0;
  logic rst;

  user_digit_entry_if bus ();

  user_digit_entry #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          raw_h[$];
  logic [3:0]  dig_h[$];
  bit          m_deb, m_pending, m_load, m_err, m_done;
  logic [3:0]  m_digit;
  int unsigned m_count;

  int vectors, miscompares;
  int loads_seen, errs_seen, dones_seen;
  int l0, e0, d0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    raw_h.delete();
    dig_h.delete();
    for (int i = 0; i < int'(D) + 2; i++) begin
      raw_h.push_back(1'b0);
      dig_h.push_back(4'd0);
    end
    m_deb = 1'b0; m_pending = 1'b0;
    m_load = 1'b0; m_err = 1'b0; m_done = 1'b0;
    m_digit = 4'd0; m_count = 0;
  endtask

  // Level is accepted once D consecutive synchronised samples all differ from it;
  // the synchroniser makes the sample used at edge T the one taken at edge T-2.
  task automatic model_edge(input bit raw, input logic [3:0] dig, input bit lo);
    bit all_diff;
    raw_h.push_front(raw);  void'(raw_h.pop_back());
    dig_h.push_front(dig);  void'(dig_h.pop_back());
    m_load = 1'b0; m_err = 1'b0; m_done = 1'b0;
    if (lo) begin
      m_count = 0;
    end else if (m_pending) begin
      if (dig_h[2] > 4'(MAXD)) begin
        m_err = 1'b1;
      end else begin
        m_digit = dig_h[2];
        m_load  = 1'b1;
        if (m_count == N_ID - 1) begin
          m_count = 0;
          m_done  = 1'b1;
        end else begin
          m_count = m_count + 1;
        end
      end
    end
    all_diff = 1'b1;
    for (int i = 2; i <= int'(D) + 1; i++)
      if (raw_h[i] == m_deb) all_diff = 1'b0;
    m_pending = 1'b0;
    if (all_diff) begin
      m_deb     = ~m_deb;
      m_pending = m_deb;
    end
  endtask

  task automatic check_all();
    chk("UserLoad",   8'(bus.UserLoad),   8'(m_load));
    chk("DigitError", 8'(bus.DigitError), 8'(m_err));
    chk("EntryDone",  8'(bus.EntryDone),  8'(m_done));
    chk("UserDigit",  8'(bus.UserDigit),  8'(m_digit));
    chk("DigitCount", 8'(bus.DigitCount), 8'(m_count));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(bus.RawLoad, bus.RawDigit, bus.logout);
    #1;
    check_all();
    if (bus.UserLoad === 1'b1)   loads_seen++;
    if (bus.DigitError === 1'b1) errs_seen++;
    if (bus.EntryDone === 1'b1)  dones_seen++;
  endtask

  task automatic do_reset(input logic hold_load);
    @(posedge clk);
    #3;
    bus.RawLoad = hold_load;
    bus.logout  = 1'b0;
    rst         = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end
    #2;
    rst = 1'b1;
  endtask

  // Bounce bits (LSB first) precede the steady press; logout is raised on the rise edge if lo.
  task automatic press(input logic [3:0] d, input logic [15:0] pat, input int nb,
                       input bit lo, input int hold);
    bus.RawDigit = d;
    for (int i = 0; i < nb; i++) begin
      bus.RawLoad = pat[i];
      step();
    end
    bus.RawLoad = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.logout = (lo && m_pending) ? 1'b1 : 1'b0;
      step();
      bus.logout = 1'b0;
      if (i > int'(D) + 3) bus.RawDigit = 4'($urandom_range(0, 15));
    end
    bus.RawLoad = 1'b0;
    for (int i = 0; i < int'(D) + 6; i++) step();
  endtask

  task automatic logout_pulse();
    bus.logout = 1'b1;
    step();
    bus.logout = 1'b0;
  endtask

  function automatic logic [15:0] rand_bounce(input int nb);
    logic [15:0] p;
    int run;
    p = '0;
    run = 0;
    for (int i = 0; i < nb - 1; i++) begin
      p[i] = (run == int'(D) - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      run  = p[i] ? run + 1 : 0;
    end
    return p;
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    loads_seen = 0; errs_seen = 0; dones_seen = 0;
    rst = 1'b0;
    bus.RawDigit = 4'd0; bus.RawLoad = 1'b0; bus.logout = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    #3;
    rst = 1'b1;

    // Clean press of 5
    l0 = loads_seen;
    press(4'd5, 16'h0, 0, 1'b0, 12);
    chk("t2_digit", 8'(bus.UserDigit), 8'd5);
    chk("t2_count", 8'(bus.DigitCount), 8'd1);
    chk("t2_loads", 8'(loads_seen - l0), 8'd1);

    // Mid-operation reset with the button held through release
    bus.RawDigit = 4'd3;
    do_reset(1'b1);
    l0 = loads_seen;
    press(4'd3, 16'h0, 0, 1'b0, 12);
    chk("t1_loads", 8'(loads_seen - l0), 8'd1);
    chk("t1_count", 8'(bus.DigitCount), 8'd1);

    // Bounce 1,0,1,1,0 then held for 100 cycles
    l0 = loads_seen;
    press(4'd8, 16'b01101, 5, 1'b0, 100);
    chk("t3_loads", 8'(loads_seen - l0), 8'd1);

    // Illegal digit
    l0 = loads_seen; e0 = errs_seen;
    press(4'd12, 16'h0, 0, 1'b0, 12);
    chk("t4_loads", 8'(loads_seen - l0), 8'd0);
    chk("t4_errs",  8'(errs_seen - e0),  8'd1);
    chk("t4_digit", 8'(bus.UserDigit),   8'd8);
    chk("t4_count", 8'(bus.DigitCount),  8'd2);

    // Full ID of four digits
    logout_pulse();
    chk("t5_clear", 8'(bus.DigitCount), 8'd0);
    d0 = dones_seen;
    for (int i = 1; i <= 4; i++) begin
      press(4'(i), 16'h0, 0, 1'b0, 10);
      chk("t5_count", 8'(bus.DigitCount), 8'(i % 4));
    end
    chk("t5_dones", 8'(dones_seen - d0), 8'd1);

    // Logout coincident with the rise after two digits
    press(4'd1, 16'h0, 0, 1'b0, 10);
    press(4'd2, 16'h0, 0, 1'b0, 10);
    l0 = loads_seen;
    press(4'd9, 16'h0, 0, 1'b1, 10);
    chk("t6_loads", 8'(loads_seen - l0), 8'd0);
    chk("t6_count", 8'(bus.DigitCount), 8'd0);
    press(4'd7, 16'h0, 0, 1'b0, 10);
    chk("t6_digit", 8'(bus.UserDigit),  8'd7);
    chk("t6_count", 8'(bus.DigitCount), 8'd1);

    // Random presses, bounces, logouts and occasional resets
    for (int n = 0; n < 30; n++) begin
      int nb;
      nb = int'($urandom_range(0, 8));
      if ($urandom_range(0, 9) == 0) begin
        bus.RawDigit = 4'($urandom_range(0, 15));
        do_reset(1'($urandom_range(0, 1)));
      end
      press(4'($urandom_range(0, 15)), rand_bounce(nb), nb,
            ($urandom_range(0, 6) == 0), int'($urandom_range(D + 4, 20)));
      if ($urandom_range(0, 5) == 0) logout_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
